// File: rtl/mips_pkg.sv
// Shared definitions for the 8-bit pipeline: widths, FSM state type and
// control-field encodings used by the MEM stage.
package mips_pkg;
    localparam int PC_W      = 12;
    localparam int DATA_W    = 8;
    localparam int REG_IDX_W = 3;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } mem_state_t;

    localparam logic MEMRW_STORE = 1'b1;
    localparam logic WBSEL_MEM   = 1'b1;
endpackage

// File: rtl/data_mem.sv
// Data memory: synchronous write, asynchronous read. With MEM_PARITY_EN
// defined, one even-parity bit is kept per word and checked on read.
module data_mem #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
`ifdef MEM_PARITY_EN
   ,output logic              o_par_err
`endif
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

`ifdef MEM_PARITY_EN
    logic r_par [DEPTH];

    // A cleared word (data 0) carries parity 0, so the sweep stays consistent.
    always_ff @(posedge clk) begin
        if (i_we) r_par[i_waddr] <= ^i_wdata;
    end

    assign o_par_err = r_par[i_raddr] ^ (^r_mem[i_raddr]);
`endif
endmodule

// File: rtl/mem_stage.sv
// MEM stage: data memory access, branch resolution and MEM/WB latch, with a
// post-reset memory-clear sweep. Optional parity checking via MEM_PARITY_EN.
module mem_stage
    import mips_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PC_W-1:0]      in_new_branch_pc,
    input  logic                 in_zero,
    input  logic [DATA_W-1:0]    in_alu_result,
    input  logic [DATA_W-1:0]    in_data_2,
    input  logic [REG_IDX_W-1:0] in_reg_write,
    input  logic                 in_MEM_mem_read_write,
    input  logic                 in_MEM_pc_src,
    input  logic                 in_WB_mem_or_alu,
    input  logic                 in_WB_reg_write_signal,
    output logic                 out_branch_taken,
    output logic [PC_W-1:0]      out_branch_pc,
    output logic                 out_stall,
    output logic [DATA_W-1:0]    out_wb_data,
    output logic [REG_IDX_W-1:0] out_reg_write,
    output logic                 out_WB_reg_write_signal,
    output logic [CNT_W-1:0]     out_store_count
`ifdef MEM_PARITY_EN
   ,output logic                 out_parity_err
`endif
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    mem_state_t           r_state;
    logic [ADDR_W-1:0]    r_clr_addr;
    logic [DATA_W-1:0]    r_wb_data;
    logic [REG_IDX_W-1:0] r_reg_write;
    logic                 r_wb_we;
    logic [CNT_W-1:0]     r_store_cnt;

    logic                 w_run;
    logic                 w_store;
    logic [ADDR_W-1:0]    w_addr;
    logic                 w_we;
    logic [ADDR_W-1:0]    w_waddr;
    logic [DATA_W-1:0]    w_wdata;
    logic [DATA_W-1:0]    w_rdata;

    assign w_run   = (r_state == RUN);
    assign w_addr  = in_alu_result[ADDR_W-1:0];
    assign w_store = w_run && (in_MEM_mem_read_write == MEMRW_STORE);

    // Reset wins over both the sweep write and a RUN store in the same cycle.
    assign w_we    = !rst && (!w_run || w_store);
    assign w_waddr = w_run ? w_addr : r_clr_addr;
    assign w_wdata = w_run ? in_data_2 : '0;

`ifdef MEM_PARITY_EN
    logic w_par_err;
    logic r_parity_err;
`endif

    data_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_addr),
        .o_rdata (w_rdata)
`ifdef MEM_PARITY_EN
       ,.o_par_err(w_par_err)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= CLEAR;
            r_clr_addr  <= '0;
            r_wb_data   <= '0;
            r_reg_write <= '0;
            r_wb_we     <= 1'b0;
            r_store_cnt <= '0;
`ifdef MEM_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                CLEAR: begin
                    r_clr_addr  <= r_clr_addr + 1'b1;
                    r_wb_data   <= '0;
                    r_reg_write <= '0;
                    r_wb_we     <= 1'b0;
`ifdef MEM_PARITY_EN
                    r_parity_err <= 1'b0;
`endif
                    if (r_clr_addr == LAST_ADDR) r_state <= RUN;
                end
                RUN: begin
                    r_wb_data   <= (in_WB_mem_or_alu == WBSEL_MEM) ? w_rdata : in_alu_result;
                    r_reg_write <= in_reg_write;
                    r_wb_we     <= in_WB_reg_write_signal;
`ifdef MEM_PARITY_EN
                    r_parity_err <= (in_WB_mem_or_alu == WBSEL_MEM) && w_par_err;
`endif
                    if (w_store && (r_store_cnt != '1))
                        r_store_cnt <= r_store_cnt + 1'b1;
                end
                default: r_state <= CLEAR;
            endcase
        end
    end

    assign out_branch_taken        = w_run && !rst && in_MEM_pc_src && in_zero;
    assign out_branch_pc           = in_new_branch_pc;
    assign out_stall               = !w_run;
    assign out_wb_data             = r_wb_data;
    assign out_reg_write           = r_reg_write;
    assign out_WB_reg_write_signal = r_wb_we;
    assign out_store_count         = r_store_cnt;
`ifdef MEM_PARITY_EN
    assign out_parity_err          = r_parity_err;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against an array-based
// reference model of memory contents, writeback latch and store counter.
module tb_mem_stage;
    localparam int ADDR_W = 8;
    localparam int CNT_W  = 4;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] bpc = '0;
    logic        zero = 1'b0;
    logic [7:0]  alu = '0;
    logic [7:0]  d2 = '0;
    logic [2:0]  rd = '0;
    logic        memrw = 1'b0;
    logic        pcsrc = 1'b0;
    logic        wbsel = 1'b0;
    logic        rws = 1'b0;
    logic        taken;
    logic [11:0] bpc_o;
    logic        stall;
    logic [7:0]  wb_data;
    logic [2:0]  rd_o;
    logic        rws_o;
    logic [CNT_W-1:0] cnt_o;
`ifdef MEM_PARITY_EN
    logic        par_err;
`endif

    mem_stage #(.ADDR_W(ADDR_W), .DATA_W(8), .CNT_W(CNT_W)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .in_new_branch_pc        (bpc),
        .in_zero                 (zero),
        .in_alu_result           (alu),
        .in_data_2               (d2),
        .in_reg_write            (rd),
        .in_MEM_mem_read_write   (memrw),
        .in_MEM_pc_src           (pcsrc),
        .in_WB_mem_or_alu        (wbsel),
        .in_WB_reg_write_signal  (rws),
        .out_branch_taken        (taken),
        .out_branch_pc           (bpc_o),
        .out_stall               (stall),
        .out_wb_data             (wb_data),
        .out_reg_write           (rd_o),
        .out_WB_reg_write_signal (rws_o),
        .out_store_count         (cnt_o)
`ifdef MEM_PARITY_EN
       ,.out_parity_err          (par_err)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0] mem_m [DEPTH];
    int         cnt_m;
    bit         run_m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_junk();
        bpc   = 12'($urandom);
        zero  = 1'b1;
        pcsrc = 1'b1;
        alu   = 8'($urandom);
        d2    = 8'($urandom_range(1, 255));
        rd    = 3'($urandom);
        memrw = 1'b1;
        wbsel = 1'($urandom);
        rws   = 1'b1;
    endtask

    // Counts stall cycles (up to lim) while hammering the inputs with stores
    // and taken branches, all of which must be ignored during the sweep.
    task automatic sweep(input int lim, output int n);
        n = 0;
        while (stall && n < lim) begin
            drive_junk();
            #1;
            chk("clear_no_branch", taken, 0);
            tick();
            n++;
            if (stall) chk("clear_no_wbwe", rws_o, 0);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
        cnt_m = 0;
        run_m = 1'b1;
    endtask

    // One RUN-mode instruction: check branch combinationally, then the
    // registered writeback one edge later against the model.
    task automatic op(input logic st, input logic sel, input logic ps, input logic z,
                      input logic [7:0] a, input logic [7:0] d, input logic [2:0] r,
                      input logic w, input logic [11:0] pc);
        logic [7:0] exp_wb;
        memrw = st; wbsel = sel; pcsrc = ps; zero = z;
        alu = a; d2 = d; rd = r; rws = w; bpc = pc;
        #1;
        chk("branch_taken", taken, {31'b0, run_m & ps & z});
        chk("branch_pc", bpc_o, {20'b0, pc});
        exp_wb = sel ? mem_m[a] : a;
        if (st) begin
            mem_m[a] = d;
            if (cnt_m < 2 ** CNT_W - 1) cnt_m++;
        end
        tick();
        chk("wb_data", wb_data, {24'b0, exp_wb});
        chk("reg_write", rd_o, {29'b0, r});
        chk("wb_we", rws_o, {31'b0, w});
        chk("store_count", cnt_o, 32'(cnt_m));
`ifdef MEM_PARITY_EN
        chk("parity_err", par_err, 0);
`endif
    endtask

    initial begin
        int n;
        run_m = 1'b0;
        cnt_m = 0;

        // Reset and full sweep
        rst = 1'b1;
        tick(); tick();
        chk("rst_wb_data", wb_data, 0);
        chk("rst_reg_write", rd_o, 0);
        chk("rst_wb_we", rws_o, 0);
        chk("rst_count", cnt_o, 0);
        rst = 1'b0;
        sweep(1000, n);
        chk("sweep_len", n, DEPTH);
        chk("stall_after_sweep", stall, 0);
        chk("count_after_sweep", cnt_o, 0);
        model_clear();

        // Cleared word reads back zero
        op(0, 1, 0, 0, 8'h7F, 8'h00, 3'd1, 1, 12'h000);
        // Store then load same address
        op(1, 0, 0, 0, 8'h10, 8'hA5, 3'd0, 0, 12'h000);
        op(0, 1, 0, 0, 8'h10, 8'h00, 3'd5, 1, 12'h000);
        chk("load_a5", wb_data, 8'hA5);
        // Branch taken / not taken
        op(0, 0, 1, 1, 8'h00, 8'h00, 3'd0, 0, 12'h3C4);
        op(0, 0, 1, 0, 8'h00, 8'h00, 3'd0, 0, 12'h3C4);

        // Counter saturation: 20 stores into a 4-bit counter
        for (int i = 0; i < 20; i++)
            op(1, 0, 0, 0, 8'(8'h40 + i), 8'(i * 7 + 3), 3'd0, 0, 12'h0);
        chk("count_saturated", cnt_o, 15);

        // Randomized traffic over a small address window so loads hit stores
        for (int i = 0; i < 300; i++)
            op(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               8'($urandom_range(0, 15)), 8'($urandom), 3'($urandom),
               1'($urandom), 12'($urandom));

        // Reset from RUN, then reset again mid-sweep with a store on the rst cycle
        run_m = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sweep(100, n);
        chk("partial_sweep", n, 100);
        drive_junk();
        alu = 8'h10; d2 = 8'h5A;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sweep(1000, n);
        chk("restart_sweep_len", n, DEPTH);
        chk("restart_count", cnt_o, 0);
        model_clear();
        op(0, 1, 0, 0, 8'h10, 8'h00, 3'd2, 1, 12'h000);
        op(0, 1, 0, 0, 8'h05, 8'h00, 3'd3, 1, 12'h000);
        op(1, 0, 1, 1, 8'h22, 8'h99, 3'd4, 0, 12'hABC);
        op(0, 1, 0, 0, 8'h22, 8'h00, 3'd6, 1, 12'h000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 8-bit pipeline; sits directly downstream of the EX/MEM pipeline register and consumes its outputs.
- Owns the data memory and performs loads and stores.
- Resolves branches and drives the PC redirect back to fetch.
- Registers the selected writeback data and destination into WB-facing outputs, acting as the MEM/WB latch.
- After reset, runs a sequential memory-clear sweep and stalls the pipeline until the sweep finishes.

Parameters:
- ADDR_W, 8, data-memory address width; depth = 2**ADDR_W words.
- DATA_W, 8, data-memory word width; must match the ALU result width.
- CNT_W, 16, width of the saturating retired-store counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_new_branch_pc  in  12  branch target from EX/MEM.
- in_zero  in  1  ALU zero flag.
- in_alu_result  in  8  ALU result; also the memory address (low ADDR_W bits).
- in_data_2  in  8  store data.
- in_reg_write  in  3  destination register index.
- in_MEM_mem_read_write  in  1  1 = store, 0 = no store (load/ALU op).
- in_MEM_pc_src  in  1  instruction is a conditional branch.
- in_WB_mem_or_alu  in  1  1 = writeback memory data, 0 = writeback ALU result.
- in_WB_reg_write_signal  in  1  instruction writes the register file.
- out_branch_taken  out  1  combinational PC redirect request.
- out_branch_pc  out  12  combinational redirect target (= in_new_branch_pc).
- out_stall  out  1  high while the clear sweep runs.
- out_wb_data  out  8  registered writeback data.
- out_reg_write  out  3  registered destination index.
- out_WB_reg_write_signal  out  1  registered register-file write enable.
- out_store_count  out  CNT_W  saturating count of committed stores.

Behaviour:
- Clocking and reset: single clock clk; rst is synchronous and active-high.
- FSM states: CLEAR and RUN.
  - rst: state=CLEAR, clr_addr=0.
  - Registered outputs on rst: out_wb_data=0, out_reg_write=0, out_WB_reg_write_signal=0, out_store_count=0.
- CLEAR:
  - Each cycle writes 0 to mem[clr_addr] and increments clr_addr.
  - out_stall=1 throughout.
  - Inputs are ignored: no store, out_WB_reg_write_signal=0, out_branch_taken=0.
  - When clr_addr==2**ADDR_W-1, that word is written and the next state is RUN. The sweep takes exactly 2**ADDR_W cycles.
- rst asserted mid-sweep restarts the sweep at address 0. rst in RUN re-enters CLEAR; memory is fully re-cleared.
- RUN:
  - out_stall=0.
  - addr = in_alu_result[ADDR_W-1:0]; upper bits are ignored when ADDR_W<8.
  - Store: if in_MEM_mem_read_write=1, mem[addr]<=in_data_2 at the rising edge.
  - Read: asynchronous, returns pre-edge contents. A store followed next cycle by a load to the same address returns the new data.
  - At each edge, out_wb_data <= in_WB_mem_or_alu ? mem[addr] : in_alu_result. Latency is 1 cycle.
  - out_reg_write <= in_reg_write; out_WB_reg_write_signal <= in_WB_reg_write_signal.
  - Each store increments out_store_count; the counter saturates at all-ones and does not wrap.
- Branch:
  - out_branch_taken = (state==RUN) & in_MEM_pc_src & in_zero. Purely combinational, zero latency.
  - out_branch_pc always equals in_new_branch_pc.
- Simultaneous events: rst has priority over any store or branch in the same cycle; the store is dropped.

Optional Feature:
- Macro: MEM_PARITY_EN.
- Defined:
  - Memory stores one even-parity bit per word. The clear sweep writes parity 0 and stores write ^data.
  - Adds port out_parity_err (out, 1). It is registered and set at the edge when a load (in_WB_mem_or_alu=1) reads a word whose stored parity mismatches.
  - out_parity_err clears on the next non-erroring cycle; reset value 0.
- Undefined: no parity storage and no out_parity_err port; behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg:
  - PC_W=12, DATA_W=8, REG_IDX_W=3.
  - FSM state enum {CLEAR, RUN}.
  - Encodings MEMRW_STORE=1, WBSEL_MEM=1.
- One natural sub-module: data_mem holds the array, the synchronous write port, the asynchronous read port and optional parity. FSM, writeback mux, branch logic and counter stay in mem_stage.

Test Plan:
- Reset with ADDR_W=8 -> out_stall=1 for exactly 256 cycles, then 0. A load from 0x7F then returns out_wb_data=0x00.
- In RUN: store 0xA5 to addr 0x10, next cycle load 0x10 with mem_or_alu=1, reg_write=3'd5, reg_write_signal=1 -> one cycle later out_wb_data=0xA5, out_reg_write=5, out_WB_reg_write_signal=1.
- pc_src=1, zero=1, new_branch_pc=0x3C4 -> same-cycle out_branch_taken=1, out_branch_pc=0x3C4. With zero=0 -> taken=0. During CLEAR -> taken=0.
- Assert rst at sweep cycle 100, then drive a store during the sweep -> sweep restarts (256 more stall cycles), store dropped, out_store_count stays 0.
- With CNT_W=4, issue 20 stores -> out_store_count stops at 15.
- With MEM_PARITY_EN defined, force a flipped bit in the stored word at addr 0x20, then load it -> out_parity_err=1 one cycle later, back to 0 after a clean load.
